packetizer_vc_multiflit: RTL

- Successor to the single-word VC packetizer in the NoC translator layer.
- Accepts one wide data word plus destination router, VC and flit count, and serialises it into a multi-flit NoC packet (head, body, tail flits), with per-flit header bits and backpressure.
- Sits between the user module's streaming output and a NoC router input port.
- Back-to-back packets are supported with zero bubble cycles.

---
 rtl/packetizer_vc_multiflit_if.sv | 31 +++
 rtl/packetizer_vc_multiflit.sv | 111 +++++++++++
 2 files changed

// File: rtl/packetizer_vc_multiflit_if.sv
// Streaming handshake bundle between the user-side source, the packetizer and the NoC router port.
// The slave view belongs to the packetizer; the master view drives its inputs and consumes its flits.
interface packetizer_vc_multiflit_if #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_OUT        = 36,
  parameter int NUM_FLITS        = 4,
  parameter int WIDTH_IN         = 124
);
  localparam int LEN_WIDTH = $clog2(NUM_FLITS + 1);

  logic [WIDTH_IN-1:0]         data_in;
  logic                        valid_in;
  logic [ADDRESS_WIDTH-1:0]    dst_in;
  logic [VC_ADDRESS_WIDTH-1:0] vc_in;
  logic [LEN_WIDTH-1:0]        len_in;
  logic                        ready_out;
  logic [WIDTH_OUT-1:0]        data_out;
  logic                        valid_out;
  logic                        ready_in;

  modport slave (
    input  data_in, valid_in, dst_in, vc_in, len_in, ready_in,
    output ready_out, data_out, valid_out
  );

  modport master (
    output data_in, valid_in, dst_in, vc_in, len_in, ready_in,
    input  ready_out, data_out, valid_out
  );
endinterface

// File: rtl/packetizer_vc_multiflit.sv
// Serialises one wide input word into a head/body/tail NoC packet of up to NUM_FLITS flits,
// with zero-bubble back-to-back packets and full flit backpressure.
module packetizer_vc_multiflit #(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_OUT        = 36,
  parameter int NUM_FLITS        = 4,
  parameter int WIDTH_IN         = 124
) (
  input logic                      clk,
  input logic                      rst_n,
  packetizer_vc_multiflit_if.slave bus
);
  localparam int BODY_PAYLOAD = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH;
  localparam int HEAD_PAYLOAD = BODY_PAYLOAD - ADDRESS_WIDTH;
  localparam int LEN_WIDTH    = $clog2(NUM_FLITS + 1);
  localparam int PAD_WIDTH    = HEAD_PAYLOAD + (NUM_FLITS - 1) * BODY_PAYLOAD;
  // One spare body slot keeps the body slice in range even for single-flit configurations.
  localparam int EXT_WIDTH    = PAD_WIDTH + BODY_PAYLOAD;

  generate
    if (WIDTH_IN > PAD_WIDTH) begin : g_width_check
      $error("WIDTH_IN exceeds the payload capacity of NUM_FLITS flits");
    end
    if (NUM_FLITS < 1 || NUM_FLITS > 8) begin : g_flits_check
      $error("NUM_FLITS must be in 1..8");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_e;

  state_e                      state_q;
  logic                        valid_q;
  logic [LEN_WIDTH-1:0]        flit_idx_q;
  logic [LEN_WIDTH-1:0]        len_q;
  logic [WIDTH_IN-1:0]         data_q;
  logic [ADDRESS_WIDTH-1:0]    dst_q;
  logic [VC_ADDRESS_WIDTH-1:0] vc_q;

  logic [LEN_WIDTH-1:0] len_eff;
  logic                 last_flit;
  logic                 ready;
  logic                 accept;

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    len_eff = bus.len_in;
    if (bus.len_in == '0 || bus.len_in > LEN_WIDTH'(NUM_FLITS)) len_eff = LEN_WIDTH'(NUM_FLITS);
  end

  assign last_flit = valid_q && (flit_idx_q == len_q - LEN_WIDTH'(1));
  // The tail handshake frees the capture registers in the same cycle, hence zero bubbles.
  assign ready     = rst_n && (state_q == IDLE || (last_flit && bus.ready_in));
  assign accept    = bus.valid_in && ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the capture registers are plain flops, so resetting them is cheap and keeps data_out clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      flit_idx_q <= '0;
      len_q      <= '0;
      data_q     <= '0;
      dst_q      <= '0;
      vc_q       <= '0;
    end else if (accept) begin
      state_q    <= SEND;
      valid_q    <= 1'b1;
      flit_idx_q <= '0;
      len_q      <= len_eff;
      data_q     <= bus.data_in;
      dst_q      <= bus.dst_in;
      vc_q       <= bus.vc_in;
    end else if (state_q == SEND && bus.ready_in) begin
      if (last_flit) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end else begin
        flit_idx_q <= flit_idx_q + LEN_WIDTH'(1);
      end
    end
  end

  logic [EXT_WIDTH-1:0]    padded;
  logic [BODY_PAYLOAD-1:0] body_payload;
  logic [WIDTH_OUT-1:0]    flit;
  int unsigned             shamt;

  always_comb begin
    padded       = EXT_WIDTH'(data_q);
    shamt        = (flit_idx_q == '0) ? 0
                 : HEAD_PAYLOAD + (int'(flit_idx_q) - 1) * BODY_PAYLOAD;
    body_payload = BODY_PAYLOAD'(padded >> shamt);
    flit         = '0;
    flit[WIDTH_OUT-1] = 1'b1;
    flit[WIDTH_OUT-2] = (flit_idx_q == '0);
    flit[WIDTH_OUT-3] = last_flit;
    flit[WIDTH_OUT-4 -: VC_ADDRESS_WIDTH] = vc_q;
    if (flit_idx_q == '0) begin
      flit[BODY_PAYLOAD-1 -: ADDRESS_WIDTH] = dst_q;
      flit[HEAD_PAYLOAD-1:0]                = padded[HEAD_PAYLOAD-1:0];
    end else begin
      flit[BODY_PAYLOAD-1:0] = body_payload;
    end
  end

  assign bus.ready_out = ready;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = valid_q ? flit : '0;
endmodule
